// File: rtl/lsq_pkg.sv
// Shared definitions for the in-order load/store scheduler: FSM state codes,
// RAM size codes and the load-data extension rule.
package lsq_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ISSUE  = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_RETIRE = 2'd3;

   localparam logic [2:0] MEM_B  = 3'b000;
   localparam logic [2:0] MEM_H  = 3'b001;
   localparam logic [2:0] MEM_W  = 3'b010;
   localparam logic [2:0] MEM_BU = 3'b100;
   localparam logic [2:0] MEM_HU = 3'b101;

   // Computed at 64 bits so any XLEN up to 64 can truncate the result.
   function automatic logic [63:0] load_ext(input logic [2:0] siz, input logic [63:0] raw);
      case (siz)
         MEM_B:   load_ext = {{56{raw[7]}}, raw[7:0]};
         MEM_BU:  load_ext = {56'd0, raw[7:0]};
         MEM_H:   load_ext = {{48{raw[15]}}, raw[15:0]};
         MEM_HU:  load_ext = {48'd0, raw[15:0]};
         default: load_ext = raw;
      endcase
   endfunction

endpackage

// File: rtl/lsq_sched_if.sv
// Bus bundle between the scheduler, the issue/resolve logic, the data RAM
// and the completion broadcast.
interface lsq_sched_if #(
   parameter int DEPTH = 8,
   parameter int TAG_W = 5,
   parameter int XLEN  = 32
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             alloc_valid;
   logic             alloc_ready;
   logic [TAG_W-1:0] alloc_tag;
   logic             alloc_store;
   logic [2:0]       alloc_size;

   logic             rslv_valid;
   logic [TAG_W-1:0] rslv_tag;
   logic [XLEN-1:0]  rslv_addr;
   logic [XLEN-1:0]  rslv_data;

   logic             mem_start;
   logic [XLEN-1:0]  mem_adr;
   logic             mem_wr;
   logic [2:0]       mem_siz;
   logic [XLEN-1:0]  mem_in;
   logic [XLEN-1:0]  mem_out;
   logic             mem_busy;
   logic             mem_done;

   logic             done_valid;
   logic [TAG_W-1:0] done_tag;
   logic [XLEN-1:0]  done_data;
   logic [CW-1:0]    count;

   modport master (
      input  alloc_valid, alloc_tag, alloc_store, alloc_size,
      input  rslv_valid, rslv_tag, rslv_addr, rslv_data,
      input  mem_out, mem_busy, mem_done,
      output alloc_ready, mem_start, mem_adr, mem_wr, mem_siz, mem_in,
      output done_valid, done_tag, done_data, count
   );

   modport slave (
      output alloc_valid, alloc_tag, alloc_store, alloc_size,
      output rslv_valid, rslv_tag, rslv_addr, rslv_data,
      output mem_out, mem_busy, mem_done,
      input  alloc_ready, mem_start, mem_adr, mem_wr, mem_siz, mem_in,
      input  done_valid, done_tag, done_data, count
   );

endinterface

// File: rtl/lsq_load_ext.sv
// Size-based sign/zero extender on the RAM read-data capture path.
module lsq_load_ext
   import lsq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      siz,
   input  logic [XLEN-1:0] raw,
   output logic [XLEN-1:0] ext
);

   assign ext = XLEN'(load_ext(siz, 64'(raw)));

endmodule

// File: rtl/lsq_sched.sv
// In-order load/store queue owning the single data-RAM port: ops enqueue in
// program order, wait for operand resolve, then issue one at a time.
module lsq_sched
   import lsq_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int TAG_W = 5,
   parameter int XLEN  = 32
) (
   input logic         clk,
   input logic         rst,
   lsq_sched_if.master bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0]             e_vld, e_rdy, e_st, hit;
   logic [DEPTH-1:0][2:0]        e_siz;
   logic [DEPTH-1:0][TAG_W-1:0]  e_tag;
   logic [DEPTH-1:0][XLEN-1:0]   e_adr, e_dat;

   logic [PW-1:0]   head, tail;
   logic [CW-1:0]   cnt;
   logic [1:0]      state;
   logic            do_alloc, do_pop, head_go;

   logic [XLEN-1:0]  adr_q, in_q, data_q, ext_data;
   logic [2:0]       siz_q;
   logic             wr_q;
   logic [TAG_W-1:0] tag_q;

   // Ready is a function of the registered count only, so a retire in the
   // same cycle cannot open a slot early.
   assign bus.alloc_ready = (cnt != CW'(DEPTH));
   assign do_alloc        = bus.alloc_valid & bus.alloc_ready;
   assign do_pop          = (state == ST_RETIRE);
   assign head_go         = e_vld[head] & e_rdy[head];

   // Resolve CAM: only valid, still-waiting entries may match.
   for (genvar i = 0; i < DEPTH; i++) begin : g_cam
      assign hit[i] = bus.rslv_valid & e_vld[i] & ~e_rdy[i] & (e_tag[i] == bus.rslv_tag);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         e_vld <= '0;
         e_rdy <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (hit[i]) e_rdy[i] <= 1'b1;
         if (do_pop) e_vld[head] <= 1'b0;
         if (do_alloc) begin
            e_vld[tail] <= 1'b1;
            e_rdy[tail] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++)
         if (hit[i]) begin
            e_adr[i] <= bus.rslv_addr;
            e_dat[i] <= bus.rslv_data;
         end
      if (do_alloc) begin
         e_st[tail]  <= bus.alloc_store;
         e_siz[tail] <= bus.alloc_size;
         e_tag[tail] <= bus.alloc_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (do_alloc) tail <= tail + PW'(1);
         if (do_pop)   head <= head + PW'(1);
         case ({do_alloc, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // RAM request fields are latched on leaving IDLE so they stay stable
   // through ISSUE, WAIT and RETIRE regardless of queue activity.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         adr_q  <= '0;
         wr_q   <= 1'b0;
         siz_q  <= MEM_W;
         in_q   <= '0;
         tag_q  <= '0;
         data_q <= '0;
      end else begin
         case (state)
            ST_IDLE: if (head_go) begin
               state <= ST_ISSUE;
               adr_q <= e_adr[head];
               wr_q  <= e_st[head];
               siz_q <= e_siz[head];
               in_q  <= e_dat[head];
            end
            ST_ISSUE: state <= ST_WAIT;
            ST_WAIT: if (bus.mem_done && !bus.mem_busy) begin
               state  <= ST_RETIRE;
               tag_q  <= e_tag[head];
               data_q <= wr_q ? '0 : ext_data;
            end
            ST_RETIRE: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   lsq_load_ext #(.XLEN(XLEN)) u_ext (
      .siz (siz_q),
      .raw (bus.mem_out),
      .ext (ext_data)
   );

   assign bus.mem_start  = (state == ST_ISSUE);
   assign bus.mem_adr    = adr_q;
   assign bus.mem_wr     = wr_q;
   assign bus.mem_siz    = siz_q;
   assign bus.mem_in     = in_q;
   assign bus.done_valid = (state == ST_RETIRE);
   assign bus.done_tag   = tag_q;
   assign bus.done_data  = data_q;
   assign bus.count      = cnt;

endmodule

// File: tb/tb_lsq_sched.sv
// Directed + randomized bench for lsq_sched with a latency-varying RAM model
// and an in-order reference built from plain arrays.
module tb_lsq_sched;
   import lsq_pkg::*;

   localparam int DEPTH = 8;
   localparam int TAG_W = 5;
   localparam int XLEN  = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lsq_sched_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) bus ();

   lsq_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] adr;
      logic        wr;
      logic [2:0]  siz;
      logic [31:0] din;
   } iss_t;

   iss_t        iss_q[$];
   logic [31:0] dtag_q[$];
   logic [31:0] ddat_q[$];
   int          checks = 0;
   int          errors = 0;

   logic [31:0] ram [0:255];
   logic [31:0] ref_mem [0:255];
   logic [31:0] ram_out;
   logic [7:0]  ram_idx;
   logic        ram_busy, ram_done, ram_active;
   logic        force_done;
   bit          ram_hang;
   int          lat;
   int          max_lat;

   assign bus.mem_busy = ram_busy;
   assign bus.mem_done = ram_done | force_done;
   assign bus.mem_out  = ram_out;

   function automatic logic [31:0] init_val(input int i);
      return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   function automatic logic [31:0] ref_ext(input logic [2:0] s, input logic [31:0] r);
      int unsigned v;
      case (s)
         3'b000: begin v = r % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
         3'b100: v = r % 256;
         3'b001: begin v = r % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
         3'b101: v = r % 65536;
         default: v = r;
      endcase
      return v;
   endfunction

   // RAM: one record per cycle that mem_start is seen, done after 0..max_lat waits.
   always @(negedge clk) begin
      if (rst) begin
         ram_busy   <= 1'b0;
         ram_done   <= 1'b0;
         ram_active <= 1'b0;
         ram_out    <= '0;
         ram_idx    <= '0;
         lat        <= 0;
         for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      end else begin
         ram_done <= 1'b0;
         if (bus.mem_start) begin
            iss_q.push_back('{bus.mem_adr, bus.mem_wr, bus.mem_siz, bus.mem_in});
            ram_idx <= bus.mem_adr[9:2];
            if (bus.mem_wr) ram[bus.mem_adr[9:2]] <= bus.mem_in;
            lat        <= int'($urandom_range(0, max_lat));
            ram_busy   <= 1'b1;
            ram_active <= 1'b1;
         end else if (ram_active && !ram_hang) begin
            if (lat == 0) begin
               ram_done   <= 1'b1;
               ram_busy   <= 1'b0;
               ram_active <= 1'b0;
               ram_out    <= ram[ram_idx];
            end else begin
               lat <= lat - 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && bus.done_valid === 1'b1) begin
         dtag_q.push_back(32'(bus.done_tag));
         ddat_q.push_back(bus.done_data);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_alloc(input int tag, input logic st, input logic [2:0] siz);
      int t = 0;
      while (!bus.alloc_ready && t < 200) begin tick(); t++; end
      if (t >= 200) chk("alloc_ready_timeout", 64'(bus.alloc_ready), 64'(1));
      bus.alloc_valid = 1'b1;
      bus.alloc_tag   = TAG_W'(tag);
      bus.alloc_store = st;
      bus.alloc_size  = siz;
      tick();
      bus.alloc_valid = 1'b0;
   endtask

   task automatic do_rslv(input int tag, input logic [31:0] adr, input logic [31:0] dat);
      bus.rslv_valid = 1'b1;
      bus.rslv_tag   = TAG_W'(tag);
      bus.rslv_addr  = adr;
      bus.rslv_data  = dat;
      tick();
      bus.rslv_valid = 1'b0;
   endtask

   task automatic wait_dones(input int n);
      int t = 0;
      while (dtag_q.size() < n && t < 600) begin tick(); t++; end
      chk("done_count", 64'(dtag_q.size()), 64'(n));
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, "_alloc_ready"}, 64'(bus.alloc_ready), 64'(1));
      chk({pfx, "_mem_start"},   64'(bus.mem_start),   64'(0));
      chk({pfx, "_mem_wr"},      64'(bus.mem_wr),      64'(0));
      chk({pfx, "_mem_adr"},     64'(bus.mem_adr),     64'(0));
      chk({pfx, "_mem_siz"},     64'(bus.mem_siz),     64'(3'b010));
      chk({pfx, "_mem_in"},      64'(bus.mem_in),      64'(0));
      chk({pfx, "_done_valid"},  64'(bus.done_valid),  64'(0));
      chk({pfx, "_done_tag"},    64'(bus.done_tag),    64'(0));
      chk({pfx, "_done_data"},   64'(bus.done_data),   64'(0));
      chk({pfx, "_count"},       64'(bus.count),       64'(0));
   endtask

   logic [2:0]  siz_tbl [0:7];
   int          b_tag [0:7];
   logic        b_st  [0:7];
   logic [2:0]  b_siz [0:7];
   logic [31:0] b_adr [0:7];
   logic [31:0] b_dat [0:7];
   int          perm  [0:7];

   initial begin
      int bd, bi, k, r, sw, t;
      logic [31:0] exp_d;
      siz_tbl = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
      rst = 1'b1;
      ram_hang = 1'b0;
      force_done = 1'b0;
      max_lat = 0;
      bus.alloc_valid = 1'b0; bus.alloc_tag = '0; bus.alloc_store = 1'b0; bus.alloc_size = 3'b010;
      bus.rslv_valid = 1'b0; bus.rslv_tag = '0; bus.rslv_addr = '0; bus.rslv_data = '0;
      tick(3);
      chk_reset("reset");
      rst = 1'b0;
      tick();

      // Store W with minimum-latency timing check.
      do_alloc(3, 1'b1, MEM_W);
      do_rslv(3, 32'h100, 32'hDEAD_BEEF);
      tick();
      chk("st_start",      64'(bus.mem_start), 64'(1));
      chk("st_wr",         64'(bus.mem_wr),    64'(1));
      chk("st_adr",        64'(bus.mem_adr),   64'(32'h100));
      chk("st_in",         64'(bus.mem_in),    64'(32'hDEAD_BEEF));
      tick();
      chk("st_start_pulse", 64'(bus.mem_start), 64'(0));
      tick();
      chk("st_done_valid", 64'(bus.done_valid), 64'(1));
      chk("st_done_tag",   64'(bus.done_tag),   64'(3));
      chk("st_done_data",  64'(bus.done_data),  64'(0));
      chk("st_adr_held",   64'(bus.mem_adr),    64'(32'h100));
      tick();
      chk("st_done_pulse", 64'(bus.done_valid), 64'(0));
      chk("st_one_start",  64'(iss_q.size()),   64'(1));

      // Byte loads: signed then unsigned.
      max_lat = 2;
      bd = dtag_q.size();
      do_alloc(4, 1'b0, MEM_B);
      do_rslv(4, 32'h100, 32'h0);
      wait_dones(bd + 1);
      chk("ldb_tag",  64'(dtag_q[bd]), 64'(4));
      chk("ldb_data", 64'(ddat_q[bd]), 64'(32'hFFFF_FFEF));
      do_alloc(4, 1'b0, MEM_BU);
      do_rslv(4, 32'h100, 32'h0);
      wait_dones(bd + 2);
      chk("ldbu_data", 64'(ddat_q[bd+1]), 64'(32'h0000_00EF));

      // Out-of-order resolve must not reorder memory access.
      bd = dtag_q.size(); bi = iss_q.size();
      for (int j = 1; j <= 3; j++) do_alloc(j, 1'b0, MEM_W);
      do_rslv(3, 32'h18, 32'h0);
      tick(6);
      chk("ooo_no_issue3", 64'(iss_q.size()), 64'(bi));
      do_rslv(2, 32'h14, 32'h0);
      tick(6);
      chk("ooo_no_issue2", 64'(iss_q.size()), 64'(bi));
      do_rslv(1, 32'h10, 32'h0);
      wait_dones(bd + 3);
      for (int j = 0; j < 3; j++) begin
         chk("ooo_tag",  64'(dtag_q[bd+j]),  64'(j + 1));
         chk("ooo_adr",  64'(iss_q[bi+j].adr), 64'(32'h10 + 4*j));
         chk("ooo_data", 64'(ddat_q[bd+j]),  64'(init_val(4 + j)));
      end

      // Fill, reject overflow, then wrap the tail after one retire.
      bd = dtag_q.size();
      for (int j = 0; j < DEPTH; j++) do_alloc(8 + j, 1'b0, MEM_W);
      chk("full_ready", 64'(bus.alloc_ready), 64'(0));
      chk("full_count", 64'(bus.count),       64'(8));
      bus.alloc_valid = 1'b1; bus.alloc_tag = 5'd20;
      tick();
      bus.alloc_valid = 1'b0;
      chk("full_reject_count", 64'(bus.count), 64'(8));
      do_rslv(8, 32'h20, 32'h0);
      wait_dones(bd + 1);
      tick();
      chk("after_retire_ready", 64'(bus.alloc_ready), 64'(1));
      chk("after_retire_count", 64'(bus.count),       64'(7));
      do_alloc(21, 1'b0, MEM_W);
      chk("wrap_count", 64'(bus.count), 64'(8));
      for (int j = 1; j < DEPTH; j++) do_rslv(8 + j, 32'(32'h20 + 4*j), 32'h0);
      do_rslv(21, 32'h60, 32'h0);
      wait_dones(bd + 9);
      for (int j = 0; j < 8; j++) begin
         chk("fill_tag",  64'(dtag_q[bd+j]), 64'(8 + j));
         chk("fill_data", 64'(ddat_q[bd+j]), 64'(init_val(8 + j)));
      end
      chk("wrap_tag",  64'(dtag_q[bd+8]), 64'(21));
      chk("wrap_data", 64'(ddat_q[bd+8]), 64'(init_val(24)));
      tick();
      chk("drain_count", 64'(bus.count), 64'(0));

      // Resolve of an absent tag, and alloc+resolve of the same tag together.
      bd = dtag_q.size(); bi = iss_q.size();
      do_rslv(7, 32'h30, 32'h0);
      tick(4);
      chk("absent_count", 64'(bus.count),   64'(0));
      chk("absent_issue", 64'(iss_q.size()), 64'(bi));
      do_alloc(7, 1'b0, MEM_W);
      tick(6);
      chk("absent_wait_issue", 64'(iss_q.size()), 64'(bi));
      chk("absent_wait_count", 64'(bus.count),    64'(1));
      do_rslv(7, 32'h30, 32'h0);
      wait_dones(bd + 1);
      chk("absent_tag",  64'(dtag_q[bd]), 64'(7));
      chk("absent_data", 64'(ddat_q[bd]), 64'(init_val(12)));
      bi = iss_q.size();
      bus.alloc_valid = 1'b1; bus.alloc_tag = 5'd9; bus.alloc_store = 1'b0; bus.alloc_size = MEM_W;
      bus.rslv_valid  = 1'b1; bus.rslv_tag  = 5'd9; bus.rslv_addr = 32'h40; bus.rslv_data = 32'h0;
      tick();
      bus.alloc_valid = 1'b0; bus.rslv_valid = 1'b0;
      tick(5);
      chk("same_cycle_no_issue", 64'(iss_q.size()), 64'(bi));
      do_rslv(9, 32'h44, 32'h0);
      wait_dones(bd + 2);
      chk("same_cycle_data", 64'(ddat_q[bd+1]), 64'(init_val(17)));
      chk("same_cycle_adr",  64'(iss_q[bi].adr), 64'(32'h44));

      // Reset while the RAM is stalled in WAIT; late done must be ignored.
      bd = dtag_q.size();
      ram_hang = 1'b1;
      do_alloc(5, 1'b0, MEM_W);
      do_rslv(5, 32'h50, 32'h0);
      t = 0;
      while (!bus.mem_start && t < 50) begin tick(); t++; end
      chk("rst_start_seen", 64'(bus.mem_start), 64'(1));
      tick();
      chk("rst_busy", 64'(bus.mem_busy), 64'(1));
      rst = 1'b1;
      tick();
      chk_reset("midrst");
      rst = 1'b0;
      ram_hang = 1'b0;
      force_done = 1'b1;
      tick();
      force_done = 1'b0;
      tick(5);
      chk("late_done_ignored", 64'(dtag_q.size()), 64'(bd));

      // Random batches against an in-order memory model.
      max_lat = 3;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      for (int b = 0; b < 30; b++) begin
         bd = dtag_q.size(); bi = iss_q.size();
         k = int'($urandom_range(1, DEPTH));
         for (int j = 0; j < k; j++) begin
            b_tag[j] = 1 + ((b * 5 + j) % 31);
            b_st[j]  = 1'($urandom_range(0, 1));
            b_siz[j] = siz_tbl[$urandom_range(0, 7)];
            b_adr[j] = 32'h80 + 4 * 32'($urandom_range(0, 15));
            b_dat[j] = $urandom;
            perm[j]  = j;
            do_alloc(b_tag[j], b_st[j], b_siz[j]);
         end
         for (int j = k - 1; j > 0; j--) begin
            r = int'($urandom_range(0, j));
            sw = perm[j]; perm[j] = perm[r]; perm[r] = sw;
         end
         for (int j = 0; j < k; j++) begin
            do_rslv(b_tag[perm[j]], b_adr[perm[j]], b_dat[perm[j]]);
            tick(int'($urandom_range(0, 2)));
         end
         wait_dones(bd + k);
         if (dtag_q.size() >= bd + k && iss_q.size() >= bi + k) begin
            for (int j = 0; j < k; j++) begin
               if (b_st[j]) begin
                  exp_d = 32'h0;
                  ref_mem[b_adr[j][9:2]] = b_dat[j];
                  chk("rnd_st_in", 64'(iss_q[bi+j].din), 64'(b_dat[j]));
               end else begin
                  exp_d = ref_ext(b_siz[j], ref_mem[b_adr[j][9:2]]);
               end
               chk("rnd_tag",  64'(dtag_q[bd+j]),     64'(b_tag[j]));
               chk("rnd_data", 64'(ddat_q[bd+j]),     64'(exp_d));
               chk("rnd_adr",  64'(iss_q[bi+j].adr),  64'(b_adr[j]));
               chk("rnd_wr",   64'(iss_q[bi+j].wr),   64'(b_st[j]));
               chk("rnd_siz",  64'(iss_q[bi+j].siz),  64'(b_siz[j]));
            end
         end
         tick(2);
      end
      chk("final_count", 64'(bus.count), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
